// File: rtl/alu_seq_p.sv
// alu_seq_p: sequential ALU with single-cycle add/sub/logic ops and an iterative shift-add multiplier.
// Operands are captured on acceptance; results and flags are registered on the edge entering DONE.
module alu_seq_p #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               cout,
  output logic               ovf,
  output logic               zero,
  output logic               err
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_next;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, mp;
  logic [2*WIDTH-1:0] mc, prod, prod_next, res_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, diff;
  logic is_mul, last, complete, cout_n, ovf_n;
  assign is_mul = op_q == 3'b010;
  assign last = cnt == CW'(WIDTH - 1);
  assign complete = state == EXEC && (!is_mul || last);
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  // Subtraction as a + ~b + 1, so the carry out is the unsigned "no borrow" flag.
  assign diff = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1);
  assign prod_next = prod + (mp[0] ? mc : '0);
  always_ff @(posedge clk)
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  always_comb
    state_next = state == IDLE ? (start ? EXEC : IDLE) :
                 state == EXEC ? (complete ? DONE : EXEC) : IDLE;
  always_comb begin
    ready = state == IDLE;
    done = state == DONE;
  end
  always_comb begin
    res_n = '0;
    cout_n = 1'b0;
    ovf_n = 1'b0;
    case (op_q)
      3'b000: begin
        res_n[WIDTH-1:0] = sum[WIDTH-1:0];
        cout_n = sum[WIDTH];
        ovf_n = a_q[WIDTH-1] == b_q[WIDTH-1] && sum[WIDTH-1] != a_q[WIDTH-1];
      end
      3'b001: begin
        res_n[WIDTH-1:0] = diff[WIDTH-1:0];
        cout_n = diff[WIDTH];
        ovf_n = a_q[WIDTH-1] != b_q[WIDTH-1] && diff[WIDTH-1] != a_q[WIDTH-1];
      end
      3'b010: begin
        res_n = prod_next;
        ovf_n = |prod_next[2*WIDTH-1:WIDTH];
      end
      3'b100: res_n[WIDTH-1:0] = a_q & b_q;
      3'b101: res_n[WIDTH-1:0] = a_q | b_q;
      3'b110: res_n[WIDTH-1:0] = a_q ^ b_q;
      3'b111: res_n[WIDTH-1:0] = ~a_q;
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      mc <= '0;
      mp <= '0;
      prod <= '0;
      cnt <= '0;
      result <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        op_q <= op;
        a_q <= a;
        b_q <= b;
        mc <= {{WIDTH{1'b0}}, a};
        mp <= b;
        prod <= '0;
        cnt <= '0;
      end
      if (state == EXEC && is_mul) begin
        prod <= prod_next;
        mc <= mc << 1;
        mp <= mp >> 1;
        cnt <= cnt + CW'(1);
      end
      if (complete) begin
        result <= res_n;
        cout <= cout_n;
        ovf <= ovf_n;
        zero <= res_n == '0;
        err <= op_q == 3'b011;
      end
    end
endmodule

// File: tb/tb_alu_seq_p.sv
// tb_alu_seq_p: randomized and directed checks of alu_seq_p against an arithmetic reference model.
module tb_alu_seq_p;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [15:0] a = '0, b = '0;
  logic ready, done, cout, ovf, zero, err;
  logic [31:0] result;
  int passed = 0, total = 0;
  alu_seq_p #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passed++;
  endtask
  // Returns {err, zero, ovf, cout, result[31:0]} from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    longint ux = longint'(x), uy = longint'(y), sx, sy, r = 0;
    bit c = 0, v = 0;
    sx = x[15] ? ux - 65536 : ux;
    sy = y[15] ? uy - 65536 : uy;
    case (o)
      3'd0: begin r = (ux + uy) % 65536; c = ux + uy > 65535; v = sx + sy > 32767 || sx + sy < -32768; end
      3'd1: begin r = (ux - uy + 65536) % 65536; c = ux >= uy; v = sx - sy > 32767 || sx - sy < -32768; end
      3'd2: begin r = ux * uy; v = r > 65535; end
      3'd4: r = ux & uy;
      3'd5: r = ux | uy;
      3'd6: r = ux ^ uy;
      3'd7: r = 65535 - ux;
      default: r = 0;
    endcase
    return {o == 3'd3, r == 0, v, c, r[31:0]};
  endfunction
  task automatic wait_done(output int k, output bit busy);
    k = 0;
    busy = 0;
    while (done !== 1'b1 && k < 40) begin
      busy |= ready;
      @(negedge clk);
      k++;
    end
  endtask
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [35:0] e;
    int k;
    bit busy;
    e = model(o, x, y);
    @(negedge clk);
    check("ready_idle", ready, 1);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    wait_done(k, busy);
    check("latency", k, o == 3'd2 ? 16 : 1);
    check("busy_ready", busy, 0);
    check("ready_in_done", ready, 0);
    check("result", result, e[31:0]);
    check("flags", {err, zero, ovf, cout}, e[35:32]);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("ready_back", ready, 1);
    check("result_hold", result, e[31:0]);
  endtask
  initial begin
    int k, extra;
    bit busy;
    start = 1; op = 3'd0; a = 16'd1; b = 16'd1;
    repeat (2) @(negedge clk);
    rst_n = 1; start = 0;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {err, zero, ovf, cout}, 0);
    @(negedge clk);
    check("rst_drop_start", ready, 1);
    run_op(3'd0, 16'hFFFF, 16'h0001);
    run_op(3'd1, 16'h8000, 16'h0001);
    run_op(3'd1, 16'h0001, 16'h0002);
    run_op(3'd2, 16'hFFFF, 16'hFFFF);
    run_op(3'd3, 16'h1234, 16'h5678);
    run_op(3'd4, 16'hF0F0, 16'hFF00);
    // A start pulse during a multiply must be ignored entirely.
    @(negedge clk);
    start = 1; op = 3'd2; a = 16'h1234; b = 16'h0056;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    start = 1; op = 3'd0; a = 16'd1; b = 16'd1;
    @(negedge clk);
    start = 0;
    wait_done(k, busy);
    check("ign_latency", k, 12);
    check("ign_result", result, 32'h1234 * 32'h56);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(done);
    end
    check("ign_no_second_done", extra, 0);
    run_op(3'd2, 16'hFFFF, 16'hFFFF);
    // Reset in the middle of a multiply aborts it and clears the outputs.
    @(negedge clk);
    start = 1; op = 3'd2; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_flags", {err, zero, ovf, cout}, 0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(done);
    end
    check("abort_no_done", extra, 0);
    run_op(3'd0, 16'h0003, 16'h0004);
    repeat (40) run_op(3'($urandom), 16'($urandom), 16'($urandom));
    run_op(3'd7, 16'h0000, 16'h1234);
    run_op(3'd0, 16'h7FFF, 16'h0001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
